pe_feeder: RTL and testbench
============================

// Module: pe_feeder
// PURPOSE
//  Transmit side of the PE load/compute protocol: the sequencer that drives a PE chain's accept_w/weight,
//  valid/input/psum and switch inputs. Host fills a weight buffer and an input/psum buffer, pulses start;
//  the block shifts weights in, then streams operands with a switch marker and signals done after drain.
//  Sits between the TPU control/host write path and the west/north edge of the PE array.
// PARAMETERS
//  DATA_W     16  operand width, signed Q8.8 (FRAC_W=8 from tpu_pkg)
//  N_W        2   weights per load = PE chain depth; weight buffer depth
//  MAX_VEC    8   input/psum buffer depth (max beats per stream)
//  DRAIN_CYC  3   idle cycles after last valid beat before done
// PORTS
//  clk          in   1            clock, rising edge
//  rst          in   1            async reset, ACTIVE-LOW (asserted when 0)
//  w_wr_en      in   1            write one weight into weight buffer
//  w_wr_data    in   DATA_W       weight, Q8.8
//  x_wr_en      in   1            write one input/psum pair into input buffer
//  x_wr_input   in   DATA_W       input operand, Q8.8
//  x_wr_psum    in   DATA_W       partial sum, Q8.8
//  start        in   1            begin load+stream sequence (pulse)
//  abort        in   1            cancel sequence, return to IDLE
//  busy         out  1            high in any state other than IDLE
//  done         out  1            one-cycle pulse on sequence completion
//  err          out  1            sticky error; cleared only by reset
//  fd_accept_w  out  1            -> pe_accept_w_in
//  fd_weight    out  DATA_W       -> pe_weight_in
//  fd_valid     out  1            -> pe_valid_in
//  fd_input     out  DATA_W       -> pe_input_in
//  fd_psum      out  DATA_W       -> pe_psum_in
//  fd_switch    out  1            -> pe_switch_in
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, FSM IDLE, both buffer counts 0, err 0. Effective immediately,
//    including mid-LOAD_W/STREAM; no partial beat survives. All outputs registered.
//  - Buffers: writes accepted only in IDLE. Write while busy, or write when count full (N_W / MAX_VEC),
//    is dropped and sets err. Simultaneous w_wr_en and x_wr_en both accepted. Data order = write order.
//  - FSM IDLE -> LOAD_W -> STREAM -> DRAIN -> IDLE.
//    IDLE: start with w_count==N_W -> LOAD_W; start with w_count!=N_W ignored, sets err.
//      start and a same-cycle write: write accepted first, start evaluated against updated count.
//    LOAD_W: N_W cycles, fd_accept_w=1, fd_weight=wbuf[0..N_W-1] in order; fd_valid=0.
//      First accept_w beat appears the cycle after start is sampled.
//    STREAM: x_count cycles (entered directly after last weight beat, no gap), fd_valid=1,
//      fd_input/fd_psum = xbuf[i]; fd_switch=1 on first STREAM beat only. x_count==0: skip to DRAIN.
//    DRAIN: DRAIN_CYC cycles, all fd_* = 0; on exit done=1 for one cycle, both counts cleared, IDLE.
//  - Outside their active state fd_weight/fd_input/fd_psum are driven 0 (not held).
//  - abort: any non-IDLE state -> IDLE next cycle, fd_* = 0, no done, buffers keep contents. Ignored in IDLE.
//    abort and start same cycle in IDLE: start wins.
//  - Total latency start->done = 1 + N_W + x_count + DRAIN_CYC cycles.
//  - No arithmetic on data; fixed-point values pass through bit-exact.
// STRUCTURE
//  - tpu_pkg: DATA_W, FRAC_W, typedef logic signed [15:0] fixed_t, feeder_state_t enum
//    {IDLE, LOAD_W, STREAM, DRAIN}.
//  - Sub-module feeder_buf #(WIDTH, DEPTH): register file + write count + read index, full flag;
//    instantiated for weights (WIDTH=DATA_W) and for input/psum (WIDTH=2*DATA_W).
//  - Top: FSM, beat counter, drain counter, err/done logic, output registers.
// TESTING
//  1 Reset: rst=0 mid-run, check every output 0 asynchronously (before next edge) and busy=0.
//  2 Nominal: weights 0x4500 (69.0), 0x0A00 (10.0); 2 pairs input 0x0200 (2.0) psum 0x3200 (50.0);
//    start -> accept_w 2 cycles (0x4500, 0x0A00), valid 2 cycles, switch on 1st only, done at start+8.
//  3 Start with 1 weight loaded -> no accept_w, busy stays 0, err=1.
//  4 Write 9 pairs (MAX_VEC=8) -> 9th dropped, err=1; stream shows exactly 8 valid beats in order.
//  5 Abort during STREAM beat 1 of 4 -> fd_* 0 next cycle, no done; restart replays same buffers.
//  6 Zero inputs: 2 weights, start -> 2 accept_w beats, no valid/switch, done at start+6.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU types and sizing for the PE feeder: operand format, buffer depths and FSM states.
package tpu_pkg;
    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 8;
    localparam int N_W       = 2;
    localparam int MAX_VEC   = 8;
    localparam int DRAIN_CYC = 3;

    localparam int WCW = $clog2(N_W + 1);
    localparam int XCW = $clog2(MAX_VEC + 1);
    localparam int BCW = (XCW > WCW) ? XCW : WCW;
    localparam int DCW = $clog2(DRAIN_CYC + 1);

    typedef logic signed [DATA_W-1:0] fixed_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN
    } feeder_state_t;
endpackage

// File: rtl/feeder_buf.sv
// Write-once-per-slot register file with fill count and a sequential read pointer.
// A write landing in the slot being read is forwarded so a same-cycle write+read sees it.
module feeder_buf #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr,
    input  logic             rd_clr,
    input  logic             rd_adv,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    rd_idx;
    logic             wr_fire;

    assign full    = (count == CW'(DEPTH));
    assign wr_fire = wr_en && !full;
    assign rd_data = (wr_fire && (rd_idx == count)) ? wr_data : mem[rd_idx[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_idx <= '0;
        end else begin
            if (clr)
                count <= '0;
            else if (wr_fire)
                count <= count + 1'b1;

            if (rd_clr)
                rd_idx <= '0;
            else if (rd_adv)
                rd_idx <= rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[count[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pe_feeder.sv
// Transmit sequencer for a PE chain: shifts N_W weights in, streams buffered input/psum beats
// with a switch marker on the first beat, drains, then pulses done.
module pe_feeder
    import tpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          w_wr_en,
    input  fixed_t        w_wr_data,
    input  logic          x_wr_en,
    input  fixed_t        x_wr_input,
    input  fixed_t        x_wr_psum,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          fd_accept_w,
    output fixed_t        fd_weight,
    output logic          fd_valid,
    output fixed_t        fd_input,
    output fixed_t        fd_psum,
    output logic          fd_switch,
    output feeder_state_t dbg_state
);
    // Handshake: fd_accept_w qualifies fd_weight and fd_valid qualifies fd_input/fd_psum;
    // there is no backpressure, the PE chain consumes one beat per cycle while qualified.
    feeder_state_t     state;
    logic [BCW-1:0]    beat;
    logic [DCW-1:0]    drain_cnt;
    logic [WCW-1:0]    w_count;
    logic [WCW-1:0]    w_count_nxt;
    logic [XCW-1:0]    x_count;
    logic              w_full;
    logic              x_full;
    logic [DATA_W-1:0] w_rd;
    logic [2*DATA_W-1:0] x_rd;
    logic              idle;
    logic              w_wr_ok;
    logic              start_ok;
    logic              w_last;
    logic              x_last;
    logic              drain_last;
    logic              finish;
    logic              to_idle;
    logic              w_adv;
    logic              x_adv;
    logic              err_set;

    assign dbg_state   = state;
    assign idle        = (state == IDLE);
    assign w_wr_ok     = w_wr_en && idle && !w_full;
    // start sees the weight count as it will be after a same-cycle write
    assign w_count_nxt = w_count + WCW'(w_wr_ok);
    assign start_ok    = idle && start && (w_count_nxt == WCW'(N_W));
    assign w_last      = (beat == BCW'(N_W));
    assign x_last      = (beat == BCW'(x_count));
    assign drain_last  = (drain_cnt == DCW'(DRAIN_CYC));
    assign finish      = (state == DRAIN) && !abort && drain_last;
    assign to_idle     = (!idle && abort) || finish;
    assign w_adv       = start_ok || ((state == LOAD_W) && !abort && !w_last);
    assign x_adv       = !abort && (((state == LOAD_W) && w_last && (x_count != '0)) ||
                                    ((state == STREAM) && !x_last));
    assign err_set     = (w_wr_en && (!idle || w_full)) ||
                         (x_wr_en && (!idle || x_full)) ||
                         (idle && start && !start_ok);

    feeder_buf #(.WIDTH(DATA_W), .DEPTH(N_W)) u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en && idle),
        .wr_data (w_wr_data),
        .clr     (finish),
        .rd_clr  (to_idle),
        .rd_adv  (w_adv),
        .count   (w_count),
        .full    (w_full),
        .rd_data (w_rd)
    );

    feeder_buf #(.WIDTH(2*DATA_W), .DEPTH(MAX_VEC)) u_xbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (x_wr_en && idle),
        .wr_data ({x_wr_input, x_wr_psum}),
        .clr     (finish),
        .rd_clr  (to_idle),
        .rd_adv  (x_adv),
        .count   (x_count),
        .full    (x_full),
        .rd_data (x_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            beat        <= '0;
            drain_cnt   <= '0;
            fd_accept_w <= 1'b0;
            fd_weight   <= '0;
            fd_valid    <= 1'b0;
            fd_input    <= '0;
            fd_psum     <= '0;
            fd_switch   <= 1'b0;
        end else begin
            // data lanes return to zero unless a beat is issued this cycle
            fd_accept_w <= 1'b0;
            fd_weight   <= '0;
            fd_valid    <= 1'b0;
            fd_input    <= '0;
            fd_psum     <= '0;
            fd_switch   <= 1'b0;
            done        <= 1'b0;
            if (err_set)
                err <= 1'b1;

            if (to_idle) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= finish;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state       <= LOAD_W;
                            busy        <= 1'b1;
                            fd_accept_w <= 1'b1;
                            fd_weight   <= w_rd;
                            beat        <= BCW'(1);
                        end
                    end
                    LOAD_W: begin
                        if (!w_last) begin
                            fd_accept_w <= 1'b1;
                            fd_weight   <= w_rd;
                            beat        <= beat + 1'b1;
                        end else if (x_count != '0) begin
                            state                <= STREAM;
                            fd_valid             <= 1'b1;
                            fd_switch            <= 1'b1;
                            {fd_input, fd_psum}  <= x_rd;
                            beat                 <= BCW'(1);
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DCW'(1);
                        end
                    end
                    STREAM: begin
                        if (!x_last) begin
                            fd_valid            <= 1'b1;
                            {fd_input, fd_psum} <= x_rd;
                            beat                <= beat + 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DCW'(1);
                        end
                    end
                    DRAIN: begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder: directed load/stream sequences, expected beats queued with their cycle stamps.
module tb_pe_feeder;
    import tpu_pkg::*;

    localparam int EW = 51;
    localparam logic [1:0] K_W = 2'd1;
    localparam logic [1:0] K_V = 2'd2;
    localparam logic [1:0] K_D = 2'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          w_wr_en = 1'b0;
    fixed_t        w_wr_data = '0;
    logic          x_wr_en = 1'b0;
    fixed_t        x_wr_input = '0;
    fixed_t        x_wr_psum = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic          err;
    logic          fd_accept_w;
    fixed_t        fd_weight;
    logic          fd_valid;
    fixed_t        fd_input;
    fixed_t        fd_psum;
    logic          fd_switch;
    feeder_state_t dbg_state;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pe_feeder dut (
        .clk         (clk),
        .rst         (rst),
        .w_wr_en     (w_wr_en),
        .w_wr_data   (w_wr_data),
        .x_wr_en     (x_wr_en),
        .x_wr_input  (x_wr_input),
        .x_wr_psum   (x_wr_psum),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .fd_accept_w (fd_accept_w),
        .fd_weight   (fd_weight),
        .fd_valid    (fd_valid),
        .fd_input    (fd_input),
        .fd_psum     (fd_psum),
        .fd_switch   (fd_switch),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {busy, done, fd_accept_w, fd_weight, fd_valid, fd_input, fd_psum, fd_switch}, 64'h0);
    endtask

    // scoreboard
    task automatic push(input logic [1:0] k, input logic sw, input int c, input logic [31:0] d);
        exp_q.push_back({k, sw, c[15:0], d});
    endtask

    task automatic observe(input logic [EW-1:0] got);
        logic [EW-1:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %0h expected nothing (cycle %0d)", got, cyc);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL beat: got %0h expected %0h (cycle %0d)", got, want, cyc);
            end
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst) begin
            if (fd_accept_w) observe({K_W, 1'b0, cyc[15:0], fd_weight, 16'h0000});
            if (fd_valid)    observe({K_V, fd_switch, cyc[15:0], fd_input, fd_psum});
            if (done)        observe({K_D, 1'b0, cyc[15:0], 32'h0});
            if (!fd_accept_w) chk("weight_idle_zero", 64'(fd_weight), 64'h0);
            if (!fd_valid)   chk("operand_idle_zero", {31'h0, fd_switch, fd_input, fd_psum}, 64'h0);
        end
    end

    // driver tasks (entered and left at a falling edge)
    task automatic wr_w(input logic [15:0] d);
        w_wr_en = 1'b1; w_wr_data = d;
        @(negedge clk);
        w_wr_en = 1'b0; w_wr_data = '0;
    endtask

    task automatic wr_x(input logic [15:0] a, input logic [15:0] p);
        x_wr_en = 1'b1; x_wr_input = a; x_wr_psum = p;
        @(negedge clk);
        x_wr_en = 1'b0; x_wr_input = '0; x_wr_psum = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1 chk("err_after_reset", 64'(err), 64'h0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d beats pending, busy=%0b after %0d cycles", exp_q.size(), busy, n);
            exp_q.delete();
        end
    endtask

    logic [15:0] t5_in [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [15:0] t5_ps [4] = '{16'hF000, 16'hE000, 16'hD000, 16'hC000};

    initial begin
        int s;
        logic [15:0] a;
        logic [15:0] p;

        // reset state
        #1 chk_quiet("reset_outputs");
        chk("reset_err", 64'(err), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // nominal: two weights, two pairs
        wr_w(16'h4500);
        wr_w(16'h0A00);
        wr_x(16'h0200, 16'h3200);
        wr_x(16'h0200, 16'h3200);
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h4500, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'h0A00, 16'h0000});
        push(K_V, 1'b1, s + 3, {16'h0200, 16'h3200});
        push(K_V, 1'b0, s + 4, {16'h0200, 16'h3200});
        push(K_D, 1'b0, s + 8, 32'h0);
        pulse_start();
        chk("busy_nominal", 64'(busy), 64'h1);
        wait_idle(40);
        chk("err_nominal", 64'(err), 64'h0);

        // zero inputs; second weight written in the same cycle as start
        wr_w(16'h0100);
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h0100, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'hFF00, 16'h0000});
        push(K_D, 1'b0, s + 6, 32'h0);
        w_wr_en = 1'b1; w_wr_data = 16'hFF00; start = 1'b1;
        @(negedge clk);
        w_wr_en = 1'b0; w_wr_data = '0; start = 1'b0;
        chk("busy_zero_inputs", 64'(busy), 64'h1);
        wait_idle(40);
        chk("err_zero_inputs", 64'(err), 64'h0);

        // start with only one weight loaded
        wr_w(16'h1234);
        pulse_start();
        chk("busy_short_start", 64'(busy), 64'h0);
        chk("err_short_start", 64'(err), 64'h1);
        repeat (3) @(negedge clk);
        chk("busy_short_later", 64'(busy), 64'h0);

        // asynchronous reset in the middle of a stream
        wr_w(16'h5678);
        for (int i = 1; i <= 4; i++) begin
            a = 16'(i) << 8;
            p = 16'(i);
            wr_x(a, p);
        end
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h1234, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'h5678, 16'h0000});
        push(K_V, 1'b1, s + 3, {16'h0100, 16'h0001});
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_quiet("async_reset_outputs");
        chk("async_reset_err", 64'(err), 64'h0);
        chk("async_reset_state", 64'(dbg_state), 64'(IDLE));
        chk("async_reset_pending", 64'(exp_q.size()), 64'h0);
        @(negedge clk);
        rst = 1'b1;
        pulse_start();
        chk("counts_cleared_err", 64'(err), 64'h1);
        chk("counts_cleared_busy", 64'(busy), 64'h0);
        do_reset();

        // input buffer overflow: ninth pair dropped
        wr_w(16'h0300);
        wr_w(16'hFD00);
        for (int i = 1; i <= 8; i++) begin
            a = 16'(i) << 8;
            p = 16'h8000 | 16'(i);
            wr_x(a, p);
        end
        chk("err_before_overflow", 64'(err), 64'h0);
        wr_x(16'h0900, 16'h8009);
        chk("err_overflow", 64'(err), 64'h1);
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h0300, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'hFD00, 16'h0000});
        for (int i = 1; i <= 8; i++) begin
            a = 16'(i) << 8;
            p = 16'h8000 | 16'(i);
            push(K_V, (i == 1), s + 2 + i, {a, p});
        end
        push(K_D, 1'b0, s + 14, 32'h0);
        pulse_start();
        wait_idle(60);
        do_reset();

        // abort during the first of four stream beats, then replay
        wr_w(16'h0080);
        wr_w(16'hFF80);
        for (int i = 0; i < 4; i++) wr_x(t5_in[i], t5_ps[i]);
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h0080, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'hFF80, 16'h0000});
        push(K_V, 1'b1, s + 3, {t5_in[0], t5_ps[0]});
        pulse_start();
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_quiet("abort_outputs");
        repeat (10) @(negedge clk);
        chk("abort_no_done_pending", 64'(exp_q.size()), 64'h0);
        chk("abort_err", 64'(err), 64'h0);
        s = cyc;
        push(K_W, 1'b0, s + 1, {16'h0080, 16'h0000});
        push(K_W, 1'b0, s + 2, {16'hFF80, 16'h0000});
        for (int i = 0; i < 4; i++) push(K_V, (i == 0), s + 3 + i, {t5_in[i], t5_ps[i]});
        push(K_D, 1'b0, s + 10, 32'h0);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        wait_idle(40);
        chk("replay_err", 64'(err), 64'h0);

        chk("final_pending", 64'(exp_q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
